// File: rtl/dbg_uart_host.sv
// dbg_uart_host: host-side initiator for the debugger UART link.
// Sends one command byte (plus four parameter bytes, LSB first, when
// cmd[7] is set) as 8N1 frames on txd, then collects a four-byte
// little-endian result from rxd. A single clock drives everything. One
// bit timer is shared by the serialiser and the deserialiser because the
// two never run at the same time.
// CLK_DIV must be even and at least 4 so the mid-bit sample point exists.
//
// Request handshake: req_ready is high only in IDLE. A request transfers on
// any rising clk edge where req_valid && req_ready. req_cmd and req_param
// are captured on that edge, so they may change afterwards. The result is
// reported by a single-cycle resp_valid pulse with no back-pressure.
// resp_data, resp_timeout and resp_error hold until the next pulse.
module dbg_uart_host #(
  parameter int CLK_DIV = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_param,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        resp_error,
  output logic        busy,
  output logic        txd,
  input  logic        rxd
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TX_CMD  = 4'd1,
    S_TX_P0   = 4'd2,
    S_TX_P1   = 4'd3,
    S_TX_P2   = 4'd4,
    S_TX_P3   = 4'd5,
    S_RX_WAIT = 4'd6,
    S_RX_BYTE = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t state_q, state_d;

  // Captured request.
  logic [7:0]    cmd_q;
  logic [31:0]   param_q;

  // Shared bit timer: cycle within the bit, and bit index within the frame
  // (0 = start, 1..8 = data LSB first, 9 = stop).
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;

  // Receive side.
  logic          rx_s1, rx_s2;
  logic [7:0]    rx_shift;
  logic [31:0]   rx_word;
  logic [1:0]    rx_byte_idx;
  logic [31:0]   to_cnt;
  logic          to_flag;
  logic          err_flag;

  // Values reported by the most recent completed transaction.
  logic [31:0]   resp_q;
  logic          to_q;
  logic          err_q;

  // Decoded helpers.
  logic          tx_state;
  logic          bit_end;
  logic          rx_sample;
  logic          rx_sync;
  logic [7:0]    tx_byte;
  logic          tx_bit;

  assign rx_sync   = rx_s2;
  assign tx_state  = (state_q == S_TX_CMD) || (state_q == S_TX_P0) ||
                     (state_q == S_TX_P1)  || (state_q == S_TX_P2) ||
                     (state_q == S_TX_P3);
  assign bit_end   = (bit_cnt == BIT_LAST);
  // The start bit is checked half a bit in, every later bit one full bit on,
  // which places data and stop samples at the middle of each bit.
  assign rx_sample = (bit_idx == 4'd0) ? (bit_cnt == HALF_LAST) : bit_end;

  // Select the byte being serialised and the line level for the current bit.
  always_comb begin
    tx_byte = cmd_q;
    case (state_q)
      S_TX_P0: tx_byte = param_q[7:0];
      S_TX_P1: tx_byte = param_q[15:8];
      S_TX_P2: tx_byte = param_q[23:16];
      S_TX_P3: tx_byte = param_q[31:24];
      default: tx_byte = cmd_q;
    endcase
    tx_bit = 1'b1;
    if (bit_idx == 4'd0) begin
      tx_bit = 1'b0;
    end else if (bit_idx <= 4'd8) begin
      tx_bit = tx_byte[3'(bit_idx - 4'd1)];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_TX_CMD;
      end
      S_TX_CMD: begin
        if (bit_end && bit_idx == 4'd9) state_d = cmd_q[7] ? S_TX_P0 : S_RX_WAIT;
      end
      S_TX_P0: begin
        if (bit_end && bit_idx == 4'd9) state_d = S_TX_P1;
      end
      S_TX_P1: begin
        if (bit_end && bit_idx == 4'd9) state_d = S_TX_P2;
      end
      S_TX_P2: begin
        if (bit_end && bit_idx == 4'd9) state_d = S_TX_P3;
      end
      S_TX_P3: begin
        if (bit_end && bit_idx == 4'd9) state_d = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        // A start bit wins over a timeout expiring in the same cycle.
        if (!rx_sync) begin
          state_d = S_RX_BYTE;
        end else if (to_cnt == TO_LAST) begin
          state_d = S_DONE;
        end
      end
      S_RX_BYTE: begin
        if (rx_sample) begin
          if (bit_idx == 4'd0 && rx_sync) begin
            state_d = S_RX_WAIT;
          end else if (bit_idx == 4'd9) begin
            state_d = (rx_byte_idx == 2'd3) ? S_DONE : S_RX_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state and the held result registers.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    resp_valid   = (state_q == S_DONE);
    txd          = tx_state ? tx_bit : 1'b1;
    resp_data    = (state_q == S_DONE) ? rx_word  : resp_q;
    resp_timeout = (state_q == S_DONE) ? to_flag  : to_q;
    resp_error   = (state_q == S_DONE) ? err_flag : err_q;
  end

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  // Datapath: request capture, bit timing, byte assembly, timeout, results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q       <= 8'd0;
      param_q     <= 32'd0;
      bit_cnt     <= '0;
      bit_idx     <= 4'd0;
      rx_shift    <= 8'd0;
      rx_word     <= 32'd0;
      rx_byte_idx <= 2'd0;
      to_cnt      <= 32'd0;
      to_flag     <= 1'b0;
      err_flag    <= 1'b0;
      resp_q      <= 32'd0;
      to_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q       <= req_cmd;
            param_q     <= req_param;
            bit_cnt     <= '0;
            bit_idx     <= 4'd0;
            rx_word     <= 32'd0;
            rx_byte_idx <= 2'd0;
            to_cnt      <= 32'd0;
            to_flag     <= 1'b0;
            err_flag    <= 1'b0;
          end
        end
        S_TX_CMD, S_TX_P0, S_TX_P1, S_TX_P2, S_TX_P3: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_RX_WAIT: begin
          to_cnt  <= to_cnt + 32'd1;
          bit_cnt <= '0;
          bit_idx <= 4'd0;
          if (rx_sync && to_cnt == TO_LAST) to_flag <= 1'b1;
        end
        S_RX_BYTE: begin
          if (rx_sample) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd0) begin
              // A high line here is a false start; RX_WAIT re-arms the timer.
              if (!rx_sync) bit_idx <= 4'd1;
            end else if (bit_idx <= 4'd8) begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
              bit_idx  <= bit_idx + 4'd1;
            end else begin
              // Stop bit: a low sample is remembered but the byte is kept.
              if (!rx_sync) err_flag <= 1'b1;
              case (rx_byte_idx)
                2'd0:    rx_word[7:0]   <= rx_shift;
                2'd1:    rx_word[15:8]  <= rx_shift;
                2'd2:    rx_word[23:16] <= rx_shift;
                default: rx_word[31:24] <= rx_shift;
              endcase
              rx_byte_idx <= rx_byte_idx + 2'd1;
              to_cnt      <= 32'd0;
              bit_idx     <= 4'd0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DONE: begin
          resp_q <= rx_word;
          to_q   <= to_flag;
          err_q  <= err_flag;
        end
        default: begin
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart_host.sv
// Bench for dbg_uart_host with CLK_DIV=4 and TIMEOUT=200. Directed
// commands feed an expected-byte queue for the txd decoder and an
// expected-response queue for the resp_valid monitor. A responder task
// plays the far end on rxd.
`timescale 1ns/1ps
module tb_dbg_uart_host;

  localparam int D  = 4;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_param;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic        resp_error;
  logic        busy;
  logic        txd;
  logic        rxd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_count = 0;
  int last_resp_cyc = 0;
  int inv_bad = 0;

  logic [7:0]  exp_tx_q[$];
  logic [33:0] exp_resp_q[$];   // {error, timeout, data}
  int          tx_start_log[$];

  dbg_uart_host #(.CLK_DIV(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_param(req_param),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .resp_error(resp_error),
    .busy(busy), .txd(txd), .rxd(rxd)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // txd decoder: every frame is sampled on all 10*D negedges so bit widths
  // and gaps are checked, not just the mid-bit values.
  initial begin : tx_mon
    logic [9:0] bits;
    logic       width_ok;
    logic       aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst_n === 1'b1 && txd === 1'b0) begin
        tx_start_log.push_back(cyc);
        bits = '0;
        width_ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 10 * D; k++) begin
          if (k > 0) begin @(negedge clk); #1; end
          if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
          if (k % D == 0) bits[k / D] = txd;
          else if (txd !== bits[k / D]) width_ok = 1'b0;
        end
        if (!aborted) begin
          check("tx_framing", {61'd0, bits[9], bits[0], width_ok}, 64'b101);
          if (exp_tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: actual byte 0x%0h required none", bits[8:1]);
          end else begin
            e = exp_tx_q.pop_front();
            check("tx_byte", bits[8:1], e);
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin : resp_mon
    logic [33:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst_n === 1'b1 && resp_valid === 1'b1) begin
        last_resp_cyc = cyc;
        resp_count++;
        check("resp_busy", busy, 1'b1);
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: actual data 0x%0h required no response", resp_data);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_data", resp_data, e[31:0]);
          check("resp_timeout", resp_timeout, e[32]);
          check("resp_error", resp_error, e[33]);
        end
      end
    end
  end

  // req_ready and busy must always be complements outside reset.
  initial begin : inv_mon
    forever begin
      @(negedge clk); #1;
      if (rst_n === 1'b1 && req_ready === busy) inv_bad++;
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Driver tasks (all called and returning at a negedge).
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_accept(output int acc);
    int n = 0;
    acc = -1;
    while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_wait: req_ready not seen within %0d cycles", n);
    end else begin
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [31:0] param, output int acc);
    exp_tx_q.push_back(cmd);
    if (cmd[7]) for (int k = 0; k < 4; k++) exp_tx_q.push_back(param[8*k +: 8]);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_param = param;
    wait_accept(acc);
    req_valid = 1'b0;
    req_cmd   = 8'($urandom_range(0, 255));
    req_param = $urandom;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (D) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (D) @(negedge clk);
    rxd = 1'b1;
    if (!stop_bit) repeat (2 * D) @(negedge clk);
  endtask

  task automatic reply_at(input int t, input logic [31:0] word, input int n, input int bad_idx);
    wait_cyc(t);
    for (int k = 0; k < n; k++) send_byte(word[8*k +: 8], (k == bad_idx) ? 1'b0 : 1'b1);
  endtask

  task automatic wait_resp(input int prev);
    int n = 0;
    while (resp_count == prev && n < 4000) begin @(negedge clk); n++; end
    checks++;
    if (resp_count == prev) begin
      errors++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles", n);
    end
  endtask

  initial begin : main
    int acc, acc2, prev, r1;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 8'd0; req_param = 32'd0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_txd", txd, 1'b1);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_timeout", resp_timeout, 1'b0);
    check("rst_resp_error", resp_error, 1'b0);

    // Command without parameters, instant reply.
    prev = resp_count;
    exp_resp_q.push_back({1'b0, 1'b0, 32'h12345678});
    issue(8'h01, 32'h0, acc);
    check("accept_busy", busy, 1'b1);
    check("accept_ready", req_ready, 1'b0);
    reply_at(acc + 10 * D, 32'h12345678, 4, -1);
    wait_resp(prev);
    check_range("latency_no_param", last_resp_cyc - acc, 10*D + 3 + 39*D + D/2 - 1, 10*D + 3 + 39*D + D/2 + 1);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", req_ready, 1'b1);

    // Command with parameters: five gapless frames.
    repeat (3) @(negedge clk);
    tx_start_log.delete();
    prev = resp_count;
    exp_resp_q.push_back({1'b0, 1'b0, 32'h00000001});
    issue(8'h85, 32'hDEADBEEF, acc);
    reply_at(acc + 50 * D, 32'h00000001, 4, -1);
    wait_resp(prev);
    check("tx_frame_count", tx_start_log.size(), 5);
    for (int i = 0; i < 5 && i < tx_start_log.size(); i++)
      check("tx_frame_start", tx_start_log[i], acc + 10 * D * i);
    check_range("latency_param", last_resp_cyc - acc, 50*D + 3 + 39*D + D/2 - 1, 50*D + 3 + 39*D + D/2 + 1);

    // Timeout after two reply bytes.
    repeat (3) @(negedge clk);
    prev = resp_count;
    exp_resp_q.push_back({1'b0, 1'b1, 32'h0000BBAA});
    issue(8'h02, 32'h0, acc);
    reply_at(acc + 10 * D, 32'h0000BBAA, 2, -1);
    wait_resp(prev);
    // Second stop sample lands at acc + 10D + 3 + D/2 + 9D + 10D.
    check_range("timeout_time", last_resp_cyc - (acc + 10*D + 3 + D/2 + 19*D), TO - 1, TO + 1);
    repeat (5) @(negedge clk);
    check("hold_data", resp_data, 32'h0000BBAA);
    check("hold_timeout", resp_timeout, 1'b1);

    // rxd noise during TX and a glitch in RX_WAIT are both ignored.
    prev = resp_count;
    exp_resp_q.push_back({1'b0, 1'b0, 32'h44332211});
    issue(8'h10, 32'h0, acc);
    check("hold_data_next_txn", resp_data, 32'h0000BBAA);
    check("hold_timeout_next_txn", resp_timeout, 1'b1);
    while (cyc < acc + 30) begin rxd = 1'($urandom_range(0, 1)); @(negedge clk); end
    rxd = 1'b1;
    wait_cyc(acc + 10 * D + 6);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    reply_at(acc + 10 * D + 30, 32'h44332211, 4, -1);
    wait_resp(prev);

    // Third stop bit low: error flagged, all four bytes returned.
    repeat (3) @(negedge clk);
    prev = resp_count;
    exp_resp_q.push_back({1'b1, 1'b0, 32'hD4C3B2A1});
    issue(8'h20, 32'h0, acc);
    reply_at(acc + 10 * D, 32'hD4C3B2A1, 4, 2);
    wait_resp(prev);

    // Reset in the middle of the second parameter byte.
    repeat (3) @(negedge clk);
    issue(8'h85, 32'h01020304, acc);
    wait_cyc(acc + 20 * D + 15);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_txd", txd, 1'b1);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_resp_error", resp_error, 1'b0);
    rst_n = 1'b1;
    exp_tx_q.delete();
    repeat (10) @(negedge clk);

    // Normal transaction after the reset.
    prev = resp_count;
    exp_resp_q.push_back({1'b0, 1'b0, 32'h5A5AA5A5});
    issue(8'h81, 32'hCAFEF00D, acc);
    reply_at(acc + 50 * D, 32'h5A5AA5A5, 4, -1);
    wait_resp(prev);

    // req_valid held across two transactions.
    repeat (3) @(negedge clk);
    prev = resp_count;
    exp_tx_q.push_back(8'h03);
    exp_resp_q.push_back({1'b0, 1'b0, 32'h0A0B0C0D});
    exp_resp_q.push_back({1'b0, 1'b0, 32'h01020304});
    req_valid = 1'b1; req_cmd = 8'h03; req_param = 32'h0;
    wait_accept(acc);
    exp_tx_q.push_back(8'h04);
    req_cmd = 8'h04;
    wait_cyc(acc + 20);
    check("b2b_ready_mid", req_ready, 1'b0);
    reply_at(acc + 10 * D, 32'h0A0B0C0D, 4, -1);
    wait_resp(prev);
    r1 = last_resp_cyc;
    prev = resp_count;
    wait_accept(acc2);
    req_valid = 1'b0;
    check("b2b_accept_cycle", acc2, r1 + 2);
    reply_at(acc2 + 10 * D, 32'h01020304, 4, -1);
    wait_resp(prev);

    // Final report.
    repeat (10) @(negedge clk);
    check("tx_queue_empty", exp_tx_q.size(), 0);
    check("resp_queue_empty", exp_resp_q.size(), 0);
    check("ready_busy_exclusive", inv_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
